// File: rtl/sipo_ctrl_pkg.sv
// Shared definitions for the serial-in/parallel-out frame receiver:
// FSM state encoding and default frame geometry / parity settings.
package sipo_ctrl_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_PARITY_EN  = 1;
    localparam int unsigned DEF_PARITY_ODD = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage : sipo_ctrl_pkg

// File: rtl/sipo_frame_ctrl_if.sv
// Bus bundle between the frame receiver and its environment.
//   start, bit_en, si : serial frame input (si LSB first, sampled on bit_en)
//   q, q_valid, q_ready : parallel word handshake
//   busy, par_err, ovr_err, err_clr : status and error clear
// slave  : receiver side (sipo_frame_ctrl)
// master : producer/consumer side
interface sipo_frame_ctrl_if
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);

    logic             start;
    logic             bit_en;
    logic             si;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             q_ready;
    logic             busy;
    logic             par_err;
    logic             ovr_err;
    logic             err_clr;

    modport slave (
        input  start, bit_en, si, q_ready, err_clr,
        output q, q_valid, busy, par_err, ovr_err
    );

    modport master (
        output start, bit_en, si, q_ready, err_clr,
        input  q, q_valid, busy, par_err, ovr_err
    );

endinterface : sipo_frame_ctrl_if

// File: rtl/sipo_w.sv
// Right-shifting serial-in/parallel-out register; new bits enter at the MSB
// so an LSB-first stream ends up in natural bit order after WIDTH shifts.
//   clk, rst : clock, async active-low reset
//   clr      : synchronous clear (wins over en)
//   en       : shift enable
//   si       : serial input
//   q        : register contents
module sipo_w #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             si,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {si, q[WIDTH-1:1]};
        end
    end

endmodule : sipo_w

// File: rtl/sipo_frame_ctrl.sv
// Serial frame receiver: collects WIDTH LSB-first bits (plus an optional
// parity bit) into a parallel word and holds it until the consumer accepts.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : sipo_frame_ctrl_if slave modport (serial in, word handshake,
//             busy / parity error / sticky overrun status, error clear)
module sipo_frame_ctrl
    import sipo_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned PARITY_EN  = DEF_PARITY_EN,
    parameter int unsigned PARITY_ODD = DEF_PARITY_ODD
) (
    input  logic             clk,
    input  logic             rst,
    sipo_frame_ctrl_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             q_valid_q, q_valid_d;
    logic             busy_q, busy_d;
    logic             par_err_q, par_err_d;
    logic             ovr_err_q, ovr_err_d;
    logic             sh_clr;
    logic             sh_en;
    logic             par_bad;
    logic [WIDTH-1:0] sh;

    // Data shift register
    sipo_w #(
        .WIDTH (WIDTH)
    ) u_sipo_w (
        .clk (clk),
        .rst (rst),
        .clr (sh_clr),
        .en  (sh_en),
        .si  (bus.si),
        .q   (sh)
    );

    // Parity check against the bit currently on si (used only in PAR)
    assign par_bad = ((^sh) ^ bus.si) != 1'(PARITY_ODD);

    // State and flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            par_err_q <= 1'b0;
            ovr_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            q_valid_q <= q_valid_d;
            busy_q    <= busy_d;
            par_err_q <= par_err_d;
            ovr_err_q <= ovr_err_d;
        end
    end

    // Next-state, counter and flag logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        q_valid_d = q_valid_q;
        par_err_d = par_err_q;
        ovr_err_d = bus.err_clr ? 1'b0 : ovr_err_q;
        sh_clr    = 1'b0;
        sh_en     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // bit_en coincident with start is deliberately dropped
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_clr  = 1'b1;
                end
            end

            SHIFT: begin
                if (bus.start) begin
                    cnt_d  = '0;
                    sh_clr = 1'b1;
                end else if (bus.bit_en) begin
                    sh_en = 1'b1;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        if (PARITY_EN != 0) begin
                            state_d = PAR;
                        end else begin
                            state_d   = HOLD;
                            q_valid_d = 1'b1;
                            par_err_d = 1'b0;
                        end
                    end
                end
            end

            PAR: begin
                if (bus.start) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    sh_clr  = 1'b1;
                end else if (bus.bit_en) begin
                    state_d   = HOLD;
                    q_valid_d = 1'b1;
                    par_err_d = par_bad;
                end
            end

            HOLD: begin
                if (q_valid_q && bus.q_ready) begin
                    q_valid_d = 1'b0;
                    par_err_d = 1'b0;
                    if (bus.start) begin
                        state_d = SHIFT;
                        cnt_d   = '0;
                        sh_clr  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bus.start) begin
                    // New frame while word pending: drop it, set sticky flag
                    ovr_err_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == SHIFT) || (state_d == PAR);
    end

    assign bus.q       = sh;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy_q;
    assign bus.par_err = par_err_q;
    assign bus.ovr_err = ovr_err_q;

endmodule : sipo_frame_ctrl

// File: doc/sipo_frame_ctrl.md
SIPO_FRAME_CTRL -- requirements
Module: sipo_frame_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame (2..32).
REQ-002 Parameter PARITY_EN, default 1: 1 = one parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 0 = even parity, 1 = odd parity.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  frame-start strobe, one cycle wide.
REQ-007 bit_en  input  1  serial bit strobe; si is sampled only when bit_en=1.
REQ-008 si  input  1  serial data, LSB first.
REQ-009 q  output  WIDTH  assembled parallel word.
REQ-010 q_valid  output  1  q holds a complete frame.
REQ-011 q_ready  input  1  consumer accepts q when q_valid=1.
REQ-012 busy  output  1  frame reception in progress.
REQ-013 par_err  output  1  parity mismatch on the word currently in q.
REQ-014 ovr_err  output  1  sticky: a start arrived while a word was pending.
REQ-015 err_clr  input  1  clears ovr_err.

Function
REQ-016 The FSM SHALL have states IDLE, SHIFT, PAR and HOLD.
REQ-017 IDLE: start=1 -> SHIFT; shift register and bit counter cleared; bit_en ignored, including when coincident with start.
REQ-018 SHIFT: each bit_en SHALL shift right, inserting si at the MSB ({si, sh[WIDTH-1:1]}), and increment the counter.
REQ-019 SHIFT: on the bit_en that brings the count to WIDTH -> PAR if PARITY_EN=1, else HOLD.
REQ-020 PAR: the next bit_en SHALL sample si as the parity bit -> HOLD; par_err = (XOR of data bits XOR parity bit) != PARITY_ODD.
REQ-021 PARITY_EN=0: par_err SHALL remain 0.
REQ-022 q_valid SHALL assert in the cycle after the final accepted bit_en and remain 1 until a q_valid&q_ready cycle.
REQ-023 q and par_err SHALL be stable throughout HOLD.
REQ-024 HOLD with q_valid&q_ready=1 -> IDLE; par_err cleared in the same edge.
REQ-025 start in SHIFT or PAR SHALL abort and restart the frame: counter and shift register cleared, state SHIFT, no error flagged.
REQ-026 start in HOLD without q_ready SHALL set ovr_err; the frame is dropped and the state remains HOLD.
REQ-027 start in HOLD together with q_ready SHALL complete the handshake and enter SHIFT, with no overrun.
REQ-028 err_clr SHALL clear ovr_err; a simultaneous set takes priority.
REQ-029 busy SHALL be 1 exactly in SHIFT and PAR.
REQ-030 The counter SHALL be $clog2(WIDTH+1) bits wide and never wrap.

Reset
REQ-031 rst=0 SHALL immediately force state IDLE, q=0, q_valid=0, busy=0, par_err=0, ovr_err=0, and clear the counter.
REQ-032 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending word; the first start after release begins a clean frame.

Structure
REQ-033 Package sipo_ctrl_pkg SHALL hold the state enumeration and the WIDTH and parity defaults.
REQ-034 The shift register SHALL be a sub-module, sipo_w, with parameter WIDTH, a shift enable and a synchronous clear; the FSM, counter and flags SHALL stay in sipo_frame_ctrl.

Verification
REQ-035 WIDTH=8, even parity; start, then bits 1,0,1,1,0,0,1,0 and parity 0 -> q=8'h4D, q_valid 1 cycle after the parity bit, par_err=0.
REQ-036 Same frame with parity bit 1 -> q=8'h4D, par_err=1; par_err clears on the q_ready handshake.
REQ-037 Word pending with q_ready=0, start pulsed -> ovr_err=1, q unchanged; err_clr -> ovr_err=0.
REQ-038 Start after 5 bits, then 8 bits of 8'hA5 and parity 0 -> q=8'hA5, no error.
REQ-039 rst pulsed low after 4 bits -> all outputs 0 immediately; next full frame 8'h3C received correctly.
REQ-040 HOLD with q_ready=1 and start in the same cycle -> SHIFT, ovr_err=0; next frame 8'hFF received.
